// File: rtl/mem_port_responder.sv
// rtl/mem_port_responder.sv - word-addressed memory model answering an accelerator's read/write handshakes
// Independent read and write FSMs share one storage array; host side preloads and peeks.
module mem_port_responder #(
  parameter int                  ADDR_WID = 7,
  parameter int                  DATA_WID = 32,
  parameter int                  RD_LAT   = 2,
  parameter int                  WR_LAT   = 1,
  parameter logic [DATA_WID-1:0] OOR_DATA = 32'hDEAD_BEEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read_enable,
  input  logic                finish_read,
  input  logic [63:0]         read_addr,
  input  logic [63:0]         read_size_output,
  input  logic                write_enable,
  input  logic                finish_write,
  input  logic [63:0]         write_addr,
  input  logic [63:0]         write_size,
  input  logic [DATA_WID-1:0] write_data,
  input  logic                done,
  input  logic [31:0]         returnvalue,
  output logic [63:0]         read_ready,
  output logic [DATA_WID-1:0] read_data,
  output logic [63:0]         write_ready,
  input  logic                load_en,
  input  logic [ADDR_WID-1:0] load_addr,
  input  logic [DATA_WID-1:0] load_data,
  input  logic [ADDR_WID-1:0] peek_addr,
  output logic [DATA_WID-1:0] peek_data,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count,
  output logic                oor_err,
  output logic                load_rej,
  output logic                done_seen,
  output logic [31:0]         ret_latched
);

  localparam int         DEPTH    = 1 << ADDR_WID;
  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
  localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_READY = 2'd2;
  localparam logic [1:0] R_ACK   = 2'd3;

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_COMMIT = 2'd1;
  localparam logic [1:0] W_READY  = 2'd2;
  localparam logic [1:0] W_ACK    = 2'd3;

  logic [DATA_WID-1:0] mem [DEPTH];

  logic [1:0]          r_state, w_state;
  logic [3:0]          r_cnt, w_cnt;
  logic [ADDR_WID-1:0] r_idx, w_idx;
  logic                r_inr, w_inr;
  logic [DATA_WID-1:0] w_data_q;
  logic                rd_rdy_q, wr_rdy_q;

  logic                fetch, commit, mem_we, load_ok;
  logic [DATA_WID-1:0] fetch_data, peek_next;

  // Sizes and byte-lane bits play no part in word decoding.
  logic unused_inputs;
  assign unused_inputs = ^{read_size_output, write_size, read_addr[1:0], write_addr[1:0]};

  function automatic logic addr_in_range(input logic [63:0] a);
    return a[63:ADDR_WID+2] == '0;
  endfunction

  assign fetch   = (r_state == R_FETCH) && (r_cnt == 4'd1);
  assign commit  = (w_state == W_COMMIT) && (w_cnt == 4'd1);
  assign mem_we  = commit && w_inr && !reset;
  assign load_ok = load_en && (r_state == R_IDLE) && (w_state == W_IDLE) && !reset;

  assign read_ready  = {63'd0, rd_rdy_q};
  assign write_ready = {63'd0, wr_rdy_q};

  // Same-cycle commit to the fetched word forwards the new data.
  always_comb begin
    fetch_data = mem[r_idx];
    if (commit && w_inr && (w_idx == r_idx)) fetch_data = w_data_q;
    if (!r_inr) fetch_data = OOR_DATA;
  end

  always_comb begin
    peek_next = mem[peek_addr];
    if (mem_we && (w_idx == peek_addr)) peek_next = w_data_q;
    else if (load_ok && (load_addr == peek_addr)) peek_next = load_data;
  end

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[w_idx] <= w_data_q;
    else if (load_ok) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_inr     <= 1'b0;
      read_data <= '0;
      rd_rdy_q  <= 1'b0;
      rd_count  <= 32'd0;
    end else begin
      rd_rdy_q <= 1'b0;
      case (r_state)
        R_IDLE: if (read_enable) begin
          r_idx   <= read_addr[ADDR_WID+1:2];
          r_inr   <= addr_in_range(read_addr);
          r_cnt   <= RD_LAT_C;
          r_state <= R_FETCH;
        end
        R_FETCH: if (fetch) begin
          read_data <= fetch_data;
          r_state   <= R_READY;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        R_READY: begin
          rd_rdy_q <= 1'b1;
          rd_count <= rd_count + 32'd1;
          r_state  <= R_ACK;
        end
        R_ACK: if (finish_read) begin
          r_idx   <= read_addr[ADDR_WID+1:2];
          r_inr   <= addr_in_range(read_addr);
          r_cnt   <= RD_LAT_C;
          r_state <= R_FETCH;
        end else if (!read_enable) begin
          r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state  <= W_IDLE;
      w_cnt    <= 4'd0;
      w_idx    <= '0;
      w_inr    <= 1'b0;
      w_data_q <= '0;
      wr_rdy_q <= 1'b0;
      wr_count <= 32'd0;
    end else begin
      wr_rdy_q <= 1'b0;
      case (w_state)
        W_IDLE: if (write_enable) begin
          w_idx    <= write_addr[ADDR_WID+1:2];
          w_inr    <= addr_in_range(write_addr);
          w_data_q <= write_data;
          w_cnt    <= WR_LAT_C;
          w_state  <= W_COMMIT;
        end
        W_COMMIT: if (commit) w_state <= W_READY;
                  else        w_cnt   <= w_cnt - 4'd1;
        W_READY: begin
          wr_rdy_q <= 1'b1;
          wr_count <= wr_count + 32'd1;
          w_state  <= W_ACK;
        end
        W_ACK: if (finish_write) begin
          w_idx    <= write_addr[ADDR_WID+1:2];
          w_inr    <= addr_in_range(write_addr);
          w_data_q <= write_data;
          w_cnt    <= WR_LAT_C;
          w_state  <= W_COMMIT;
        end else if (!write_enable) begin
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      peek_data   <= '0;
      oor_err     <= 1'b0;
      load_rej    <= 1'b0;
      done_seen   <= 1'b0;
      ret_latched <= 32'd0;
    end else begin
      peek_data <= peek_next;
      if ((fetch && !r_inr) || (commit && !w_inr)) oor_err <= 1'b1;
      if (load_en && !load_ok) load_rej <= 1'b1;
      if (done) begin
        done_seen   <= 1'b1;
        ret_latched <= returnvalue;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_responder.sv
// tb/tb_mem_port_responder.sv - randomized scoreboard bench for mem_port_responder
// Reference memory resolves reads/writes by edge number; a monitor pops expectations on ready pulses.
module tb_mem_port_responder;
  localparam int          ADDR_WID = 7;
  localparam int          DATA_WID = 32;
  localparam int          RD_LAT   = 2;
  localparam int          WR_LAT   = 1;
  localparam int          DEPTH    = 1 << ADDR_WID;
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  logic                clk, reset;
  logic                read_enable, finish_read, write_enable, finish_write, done;
  logic [63:0]         read_addr, read_size_output, write_addr, write_size;
  logic [31:0]         write_data, returnvalue, load_data, read_data, peek_data;
  logic [63:0]         read_ready, write_ready;
  logic                load_en;
  logic [ADDR_WID-1:0] load_addr, peek_addr;
  logic [31:0]         rd_count, wr_count, ret_latched;
  logic                oor_err, load_rej, done_seen;

  mem_port_responder #(
    .ADDR_WID(ADDR_WID), .DATA_WID(DATA_WID), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .OOR_DATA(OOR_DATA)
  ) dut (
    .clk(clk), .reset(reset),
    .read_enable(read_enable), .finish_read(finish_read), .read_addr(read_addr),
    .read_size_output(read_size_output),
    .write_enable(write_enable), .finish_write(finish_write), .write_addr(write_addr),
    .write_size(write_size), .write_data(write_data),
    .done(done), .returnvalue(returnvalue),
    .read_ready(read_ready), .read_data(read_data), .write_ready(write_ready),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .peek_addr(peek_addr), .peek_data(peek_data),
    .rd_count(rd_count), .wr_count(wr_count), .oor_err(oor_err), .load_rej(load_rej),
    .done_seen(done_seen), .ret_latched(ret_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int unsigned at; logic [63:0] addr; logic [31:0] data; } op_t;
  typedef struct { int unsigned at; logic [31:0] data; } exp_t;

  op_t         pend_r[$], pend_w[$];
  exp_t        rd_exp_q[$];
  int unsigned wr_exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  bit          exp_oor;
  int unsigned exp_rd_cnt, exp_wr_cnt;
  int unsigned cyc = 0;
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit in_range(input logic [63:0] a);
    return a < 64'(4 * DEPTH);
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a / 64'd4) % 64'(DEPTH));
  endfunction

  // Reference model: writes land on their commit edge before reads sample the same edge.
  always begin
    op_t  o;
    exp_t e;
    @(posedge clk);
    cyc++;
    while (pend_w.size() > 0 && pend_w[0].at == cyc) begin
      o = pend_w.pop_front();
      if (in_range(o.addr)) ref_mem[widx(o.addr)] = o.data;
      else exp_oor = 1'b1;
    end
    while (pend_r.size() > 0 && pend_r[0].at == cyc) begin
      o = pend_r.pop_front();
      e.at = cyc + 1;
      if (in_range(o.addr)) e.data = ref_mem[widx(o.addr)];
      else begin
        e.data  = OOR_DATA;
        exp_oor = 1'b1;
      end
      rd_exp_q.push_back(e);
    end
  end

  always begin
    exp_t        e;
    int unsigned w;
    @(negedge clk);
    if (!reset) begin
      if (read_ready != 64'd0) begin
        chk("read_ready_value", read_ready, 64'd1);
        if (rd_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read_ready: actual pulse at cycle %0d, required none", cyc);
        end else begin
          e = rd_exp_q.pop_front();
          exp_rd_cnt++;
          chk("read_data", 64'(read_data), 64'(e.data));
          chk("read_latency", 64'(cyc), 64'(e.at));
          chk("rd_count", 64'(rd_count), 64'(exp_rd_cnt));
          chk("oor_err_at_read", 64'(oor_err), 64'(exp_oor));
        end
      end
      if (write_ready != 64'd0) begin
        chk("write_ready_value", write_ready, 64'd1);
        if (wr_exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write_ready: actual pulse at cycle %0d, required none", cyc);
        end else begin
          w = wr_exp_q.pop_front();
          exp_wr_cnt++;
          chk("write_latency", 64'(cyc), 64'(w));
          chk("wr_count", 64'(wr_count), 64'(exp_wr_cnt));
        end
      end
    end
  end

  task automatic wait_rd();
    int t = 0;
    while (read_ready[0] !== 1'b1 && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) begin
      tests++; fails++;
      $display("FAIL read_ready_timeout: actual no pulse in 64 cycles, required a pulse");
    end
  endtask

  task automatic wait_wr();
    int t = 0;
    while (write_ready[0] !== 1'b1 && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) begin
      tests++; fails++;
      $display("FAIL write_ready_timeout: actual no pulse in 64 cycles, required a pulse");
    end
  endtask

  task automatic read_burst(input logic [63:0] a, input int n);
    op_t o;
    for (int i = 0; i < n; i++) begin
      read_addr = a + 64'(4 * i);
      if (i == 0) read_enable = 1'b1; else finish_read = 1'b1;
      o.at = cyc + 1 + RD_LAT; o.addr = read_addr; o.data = 32'd0;
      pend_r.push_back(o);
      @(negedge clk);
      finish_read = 1'b0;
      wait_rd();
    end
    read_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_burst(input logic [63:0] a, input int n, input logic [31:0] base, input bit rnd);
    op_t o;
    for (int i = 0; i < n; i++) begin
      write_addr = a + 64'(4 * i);
      write_data = rnd ? $urandom : base + 32'(i);
      if (i == 0) write_enable = 1'b1; else finish_write = 1'b1;
      o.at = cyc + 1 + WR_LAT; o.addr = write_addr; o.data = write_data;
      pend_w.push_back(o);
      wr_exp_q.push_back(cyc + 2 + WR_LAT);
      @(negedge clk);
      finish_write = 1'b0;
      wait_wr();
    end
    write_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_word(input int idx, input logic [31:0] d);
    load_en = 1'b1; load_addr = ADDR_WID'(idx); load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic peek_chk(input int idx);
    peek_addr = ADDR_WID'(idx);
    @(negedge clk);
    chk($sformatf("peek_word_%0d", idx), 64'(peek_data), 64'(ref_mem[idx]));
  endtask

  function automatic logic [63:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 64'(4 * DEPTH) + 64'($urandom_range(0, 255));
    return 64'($urandom_range(0, 4 * DEPTH - 1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, wa;
    int          op, rn, wn, dly, pulses;
    reset = 1'b1; read_enable = 0; finish_read = 0; write_enable = 0; finish_write = 0;
    read_addr = 0; write_addr = 0; read_size_output = 64'd4; write_size = 64'd4;
    write_data = 0; done = 0; returnvalue = 0; load_en = 0; load_addr = 0; load_data = 0;
    peek_addr = 0; exp_oor = 0; exp_rd_cnt = 0; exp_wr_cnt = 0;
    repeat (3) @(negedge clk);
    chk("reset_read_ready", read_ready, 64'd0);
    chk("reset_write_ready", write_ready, 64'd0);
    chk("reset_read_data", 64'(read_data), 64'd0);
    chk("reset_peek_data", 64'(peek_data), 64'd0);
    chk("reset_counts", {rd_count, wr_count}, 64'd0);
    chk("reset_flags", 64'({oor_err, load_rej, done_seen}), 64'd0);
    chk("reset_ret_latched", 64'(ret_latched), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) load_word(i, (i < 4) ? 32'(10 * (i + 1)) : $urandom);

    read_burst(64'd0, 4);
    chk("burst_rd_count", 64'(rd_count), 64'd4);

    write_burst(64'h10, 3, 32'd7, 1'b0);
    for (int i = 4; i < 7; i++) peek_chk(i);
    chk("burst_word5_is_8", 64'(ref_mem[5]), 64'd8);
    chk("burst_wr_count", 64'(wr_count), 64'd3);

    read_burst(64'h200, 1);
    chk("oor_read_data", 64'(read_data), 64'hDEAD_BEEF);
    chk("oor_err_set", 64'(oor_err), 64'd1);
    write_burst(64'h204, 1, 32'h1234, 1'b0);
    peek_chk(1);

    fork
      read_burst(64'h20, 1);
      begin
        repeat (RD_LAT - WR_LAT) @(negedge clk);
        write_burst(64'h20, 1, 32'hCAFE, 1'b0);
      end
    join
    chk("same_cycle_read_new_data", 64'(read_data), 64'hCAFE);

    fork
      read_burst(64'h24, 1);
      begin
        @(negedge clk);
        load_en = 1'b1; load_addr = 7'd9; load_data = 32'h0BAD;
        @(negedge clk);
        load_en = 1'b0;
      end
    join
    chk("load_rej_set", 64'(load_rej), 64'd1);
    peek_chk(9);

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      ra = rand_addr();
      wa = ($urandom_range(0, 3) == 0) ? ra : rand_addr();
      rn = $urandom_range(1, 4);
      wn = $urandom_range(1, 4);
      dly = $urandom_range(0, 3);
      case (op)
        0: read_burst(ra, rn);
        1: write_burst(wa, wn, 32'd0, 1'b1);
        2: fork
             read_burst(ra, rn);
             begin
               repeat (dly) @(negedge clk);
               write_burst(wa, wn, 32'd0, 1'b1);
             end
           join
        default: repeat (dly + 1) @(negedge clk);
      endcase
    end
    for (int i = 0; i < DEPTH; i++) peek_chk(i);
    chk("read_queue_drained", 64'(rd_exp_q.size()), 64'd0);
    chk("write_queue_drained", 64'(wr_exp_q.size()), 64'd0);

    read_enable = 1'b1; read_addr = 64'h8;
    write_enable = 1'b1; write_addr = 64'hC; write_data = ~ref_mem[3];
    @(negedge clk);
    reset = 1'b1; read_enable = 1'b0; write_enable = 1'b0;
    exp_rd_cnt = 0; exp_wr_cnt = 0; exp_oor = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rd_count", 64'(rd_count), 64'd0);
    chk("abort_wr_count", 64'(wr_count), 64'd0);
    chk("abort_read_data", 64'(read_data), 64'd0);
    chk("abort_flags", 64'({oor_err, load_rej, done_seen}), 64'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (read_ready[0] || write_ready[0]) pulses++;
    end
    chk("abort_no_ready_pulse", 64'(pulses), 64'd0);
    peek_chk(3);
    peek_chk(2);

    done = 1'b1; returnvalue = 32'h55;
    @(negedge clk);
    done = 1'b0; returnvalue = 32'h99;
    chk("done_seen", 64'(done_seen), 64'd1);
    chk("ret_latched_first", 64'(ret_latched), 64'h55);
    done = 1'b1; returnvalue = 32'h66;
    @(negedge clk);
    done = 1'b0; returnvalue = 32'h77;
    @(negedge clk);
    chk("ret_latched_recapture", 64'(ret_latched), 64'h66);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
